// File: rtl/timer0_unit_pkg.sv
// Shared definitions for the timer0 block: I/O addresses, flag/mask bit
// positions and the clock-select / compare-output encodings.
package timer0_unit_pkg;

    localparam logic [5:0] ADR_OCR0  = 6'h31;
    localparam logic [5:0] ADR_TCNT0 = 6'h32;
    localparam logic [5:0] ADR_TCCR0 = 6'h33;
    localparam logic [5:0] ADR_TIFR  = 6'h36;
    localparam logic [5:0] ADR_TIMSK = 6'h37;

    localparam int TIFR_TOV0   = 0;
    localparam int TIFR_OCF0   = 1;
    localparam int TIMSK_TOIE0 = 0;
    localparam int TIMSK_OCIE0 = 1;

    typedef enum logic [2:0] {
        CS_STOP    = 3'd0,
        CS_DIV1    = 3'd1,
        CS_DIV8    = 3'd2,
        CS_DIV32   = 3'd3,
        CS_DIV64   = 3'd4,
        CS_DIV128  = 3'd5,
        CS_DIV256  = 3'd6,
        CS_DIV1024 = 3'd7
    } cs_e;

    typedef enum logic [1:0] {
        COM_NONE   = 2'b00,
        COM_TOGGLE = 2'b01,
        COM_CLEAR  = 2'b10,
        COM_SET    = 2'b11
    } com_e;

    // Low prescaler bits that must all be ones for a tick; zero mask means every cycle.
    function automatic logic [9:0] prescMask(input cs_e cs);
        logic [9:0] mask;
        mask = 10'h000;
        case (cs)
            CS_DIV8:    mask = 10'h007;
            CS_DIV32:   mask = 10'h01F;
            CS_DIV64:   mask = 10'h03F;
            CS_DIV128:  mask = 10'h07F;
            CS_DIV256:  mask = 10'h0FF;
            CS_DIV1024: mask = 10'h3FF;
            default:    mask = 10'h000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/timer0_unit_prescaler.sv
// Free-running 10-bit prescaler for timer0; emits a one-cycle count tick
// at the rate chosen by the clock-select field.
module timer0_prescaler
    import timer0_unit_pkg::*;
(
    input  logic cp2,
    input  logic ireset,
    input  cs_e  i_cs,
    output logic o_tick
);

    logic [9:0] r_count;
    logic [9:0] w_mask;

    assign w_mask = prescMask(i_cs);

    // Held at zero while stopped so a restart always begins a full period.
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            r_count <= '0;
        end else if (i_cs == CS_STOP) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 10'd1;
        end
    end

    assign o_tick = (i_cs != CS_STOP) && ((r_count & w_mask) == w_mask);

endmodule

// File: rtl/timer0_unit.sv
// Timer0: 8-bit counter with compare match, CTC mode, overflow and
// compare interrupts, output-compare pin and an I/O-mapped register file.
module timer0_unit
    import timer0_unit_pkg::*;
#(
    parameter int IRQ_CMP_NUM = 14,
    parameter int IRQ_OVF_NUM = 15
) (
    input  logic       cp2,
    input  logic       ireset,
    input  logic [5:0] adr,
    input  logic       iore,
    input  logic       iowe,
    input  logic [7:0] dbusin,
    output logic [7:0] dbusout,
    output logic       out_en,
    input  logic       irqack,
    input  logic [4:0] irqackad,
    output logic       irq_cmp,
    output logic       irq_ovf,
    output logic       oc0
);

    localparam logic [4:0] CMP_VEC = 5'(IRQ_CMP_NUM);
    localparam logic [4:0] OVF_VEC = 5'(IRQ_OVF_NUM);

    logic [7:0] r_ocr;
    logic [7:0] r_tcnt;
    cs_e        r_cs;
    logic       r_ctc;
    com_e       r_com;
    logic       r_tov;
    logic       r_ocf;
    logic       r_toie;
    logic       r_ocie;
    logic       r_oc0;
    logic       r_skipCmp;

    logic       w_tick;
    logic       w_wrOcr;
    logic       w_wrTcnt;
    logic       w_wrTccr;
    logic       w_wrTifr;
    logic       w_wrTimsk;
    logic       w_match;
    logic       w_ovf;
    logic       w_clrOcf;
    logic       w_clrTov;
    logic       w_hit;
    logic [7:0] w_tcntNext;
    logic [7:0] w_rdData;

    timer0_prescaler u_prescaler (
        .cp2    (cp2),
        .ireset (ireset),
        .i_cs   (r_cs),
        .o_tick (w_tick)
    );

    assign w_wrOcr   = iowe && (adr == ADR_OCR0);
    assign w_wrTcnt  = iowe && (adr == ADR_TCNT0);
    assign w_wrTccr  = iowe && (adr == ADR_TCCR0);
    assign w_wrTifr  = iowe && (adr == ADR_TIFR);
    assign w_wrTimsk = iowe && (adr == ADR_TIMSK);

    // A CPU write to TCNT0 owns that edge and blanks the compare on the next tick.
    assign w_match = w_tick && !w_wrTcnt && !r_skipCmp && (r_tcnt == r_ocr);
    assign w_ovf   = w_tick && !w_wrTcnt && (r_tcnt == 8'hFF);

    assign w_clrOcf = (w_wrTifr && dbusin[TIFR_OCF0]) || (irqack && (irqackad == CMP_VEC));
    assign w_clrTov = (w_wrTifr && dbusin[TIFR_TOV0]) || (irqack && (irqackad == OVF_VEC));

    always_comb begin
        w_tcntNext = r_tcnt;
        if (w_wrTcnt) begin
            w_tcntNext = dbusin;
        end else if (w_tick) begin
            w_tcntNext = (w_match && r_ctc) ? 8'h00 : r_tcnt + 8'h01;
        end
    end

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            r_ocr  <= '0;
            r_cs   <= CS_STOP;
            r_ctc  <= 1'b0;
            r_com  <= COM_NONE;
            r_toie <= 1'b0;
            r_ocie <= 1'b0;
        end else begin
            if (w_wrOcr) begin
                r_ocr <= dbusin;
            end
            if (w_wrTccr) begin
                r_cs  <= cs_e'(dbusin[2:0]);
                r_ctc <= dbusin[3];
                r_com <= com_e'(dbusin[5:4]);
            end
            if (w_wrTimsk) begin
                r_toie <= dbusin[TIMSK_TOIE0];
                r_ocie <= dbusin[TIMSK_OCIE0];
            end
        end
    end

    // Flag setting takes priority over any clear landing on the same edge.
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            r_tcnt    <= '0;
            r_skipCmp <= 1'b0;
            r_tov     <= 1'b0;
            r_ocf     <= 1'b0;
            r_oc0     <= 1'b0;
        end else begin
            r_tcnt <= w_tcntNext;
            if (w_wrTcnt) begin
                r_skipCmp <= 1'b1;
            end else if (w_tick) begin
                r_skipCmp <= 1'b0;
            end
            r_ocf <= w_match || (r_ocf && !w_clrOcf);
            r_tov <= w_ovf || (r_tov && !w_clrTov);
            if (w_match) begin
                case (r_com)
                    COM_TOGGLE: r_oc0 <= ~r_oc0;
                    COM_CLEAR:  r_oc0 <= 1'b0;
                    COM_SET:    r_oc0 <= 1'b1;
                    default:    r_oc0 <= r_oc0;
                endcase
            end
        end
    end

    always_comb begin
        w_rdData = 8'h00;
        w_hit    = 1'b0;
        case (adr)
            ADR_OCR0: begin
                w_hit    = 1'b1;
                w_rdData = r_ocr;
            end
            ADR_TCNT0: begin
                w_hit    = 1'b1;
                w_rdData = r_tcnt;
            end
            ADR_TCCR0: begin
                w_hit    = 1'b1;
                w_rdData = {2'b00, r_com, r_ctc, r_cs};
            end
            ADR_TIFR: begin
                w_hit                = 1'b1;
                w_rdData[TIFR_TOV0]  = r_tov;
                w_rdData[TIFR_OCF0]  = r_ocf;
            end
            ADR_TIMSK: begin
                w_hit                 = 1'b1;
                w_rdData[TIMSK_TOIE0] = r_toie;
                w_rdData[TIMSK_OCIE0] = r_ocie;
            end
            default: begin
                w_hit    = 1'b0;
                w_rdData = 8'h00;
            end
        endcase
    end

    assign out_en  = iore && w_hit;
    assign dbusout = out_en ? w_rdData : 8'h00;

    assign irq_cmp = r_ocf && r_ocie;
    assign irq_ovf = r_tov && r_toie;
    assign oc0     = r_oc0;

endmodule

// File: tb/tb_timer0_unit.sv
// Self-checking bench for timer0_unit: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model of the timer.
module tb_timer0_unit;

    logic       cp2;
    logic       ireset;
    logic [5:0] adr;
    logic       iore;
    logic       iowe;
    logic [7:0] dbusin;
    logic [7:0] dbusout;
    logic       out_en;
    logic       irqack;
    logic [4:0] irqackad;
    logic       irq_cmp;
    logic       irq_ovf;
    logic       oc0;

    int testsRun;
    int testsFailed;

    int m_tcnt, m_ocr, m_cs, m_ctc, m_com, m_tov, m_ocf, m_toie, m_ocie, m_oc, m_presc, m_skip;

    timer0_unit #(
        .IRQ_CMP_NUM (14),
        .IRQ_OVF_NUM (15)
    ) dut (
        .cp2      (cp2),
        .ireset   (ireset),
        .adr      (adr),
        .iore     (iore),
        .iowe     (iowe),
        .dbusin   (dbusin),
        .dbusout  (dbusout),
        .out_en   (out_en),
        .irqack   (irqack),
        .irqackad (irqackad),
        .irq_cmp  (irq_cmp),
        .irq_ovf  (irq_ovf),
        .oc0      (oc0)
    );

    initial cp2 = 1'b0;
    always #10 cp2 = ~cp2;

    function automatic int divOf(input int cs);
        case (cs)
            1:       return 1;
            2:       return 8;
            3:       return 32;
            4:       return 64;
            5:       return 128;
            6:       return 256;
            default: return 1024;
        endcase
    endfunction

    function automatic logic [5:0] regAddr(input int i);
        case (i)
            0:       return 6'h31;
            1:       return 6'h32;
            2:       return 6'h33;
            3:       return 6'h36;
            default: return 6'h37;
        endcase
    endfunction

    function automatic logic [7:0] modelRead(input logic [5:0] a);
        case (a)
            6'h31:   return 8'(m_ocr);
            6'h32:   return 8'(m_tcnt);
            6'h33:   return 8'(m_com * 16 + m_ctc * 8 + m_cs);
            6'h36:   return 8'(m_ocf * 2 + m_tov);
            6'h37:   return 8'(m_ocie * 2 + m_toie);
            default: return 8'h00;
        endcase
    endfunction

    task automatic modelReset();
        m_tcnt = 0; m_ocr = 0; m_cs = 0; m_ctc = 0; m_com = 0; m_tov = 0;
        m_ocf = 0; m_toie = 0; m_ocie = 0; m_oc = 0; m_presc = 0; m_skip = 0;
    endtask

    // Next-state of the timer as described behaviourally, from the inputs about to be clocked.
    task automatic modelStep();
        int  div;
        int  nxt;
        bit  tick, wrT, match, ovf, clrO, clrT;
        div   = divOf(m_cs);
        tick  = (m_cs != 0) && ((m_presc % div) == div - 1);
        wrT   = iowe && (adr == 6'h32);
        match = tick && !wrT && (m_skip == 0) && (m_tcnt == m_ocr);
        ovf   = tick && !wrT && (m_tcnt == 255);
        clrO  = (iowe && adr == 6'h36 && dbusin[1]) || (irqack && irqackad == 5'd14);
        clrT  = (iowe && adr == 6'h36 && dbusin[0]) || (irqack && irqackad == 5'd15);
        if (wrT) nxt = int'(dbusin);
        else if (tick) nxt = (match && m_ctc != 0) ? 0 : (m_tcnt + 1) % 256;
        else nxt = m_tcnt;
        m_presc = (m_cs == 0) ? 0 : (m_presc + 1) % 1024;
        if (wrT) m_skip = 1;
        else if (tick) m_skip = 0;
        if (match) begin
            if (m_com == 1) m_oc = 1 - m_oc;
            else if (m_com == 2) m_oc = 0;
            else if (m_com == 3) m_oc = 1;
        end
        m_ocf  = match ? 1 : (clrO ? 0 : m_ocf);
        m_tov  = ovf ? 1 : (clrT ? 0 : m_tov);
        m_tcnt = nxt;
        if (iowe && adr == 6'h31) m_ocr = int'(dbusin);
        if (iowe && adr == 6'h33) begin
            m_cs  = int'(dbusin[2:0]);
            m_ctc = int'(dbusin[3]);
            m_com = int'(dbusin[5:4]);
        end
        if (iowe && adr == 6'h37) begin
            m_toie = int'(dbusin[0]);
            m_ocie = int'(dbusin[1]);
        end
    endtask

    task automatic cycle();
        if (ireset) modelStep();
        else modelReset();
        @(posedge cp2);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic writeReg(input logic [5:0] a, input logic [7:0] d);
        adr = a; dbusin = d; iowe = 1'b1;
        cycle();
        iowe = 1'b0;
    endtask

    task automatic readReg(input logic [5:0] a, output logic [7:0] d, output logic en);
        adr = a; iore = 1'b1;
        #1;
        d = dbusout; en = out_en;
        iore = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       en;
        ireset = 1'b0;
        idle(2);
        ireset = 1'b1;
        writeReg(6'h31, 8'h02);
        writeReg(6'h37, 8'h03);
        writeReg(6'h33, 8'h31);
        idle(4);
        readReg(6'h32, d, en);
        testsRun++;
        if (d !== 8'h04) begin testsFailed++; $display("[TB] FAIL reset_precount_tcnt: got %02h expected 04", d); end
        testsRun++;
        if (irq_cmp !== 1'b1 || oc0 !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL reset_precount_cmp: got irq_cmp=%b oc0=%b expected 1 1", irq_cmp, oc0);
        end
        ireset = 1'b0;
        modelReset();
        #1;
        for (int i = 0; i < 5; i++) begin
            readReg(regAddr(i), d, en);
            testsRun++;
            if (d !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_reg_%02h: got %02h expected 00", regAddr(i), d); end
        end
        testsRun++;
        if (irq_cmp !== 1'b0 || irq_ovf !== 1'b0 || oc0 !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL reset_outputs: got irq_cmp=%b irq_ovf=%b oc0=%b expected 0 0 0", irq_cmp, irq_ovf, oc0);
        end
        idle(2);
        ireset = 1'b1;
        idle(5);
        readReg(6'h32, d, en);
        testsRun++;
        if (d !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_no_tick_after_release: got %02h expected 00", d); end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic       en;
        logic [7:0] expCnt;
        writeReg(6'h33, 8'h00);
        writeReg(6'h36, 8'h03);
        writeReg(6'h31, 8'h00);
        writeReg(6'h32, 8'hFD);
        writeReg(6'h37, 8'h01);
        writeReg(6'h33, 8'h01);
        for (int e = 1; e <= 3; e++) begin
            cycle();
            expCnt = 8'(8'hFD + e);
            readReg(6'h32, d, en);
            testsRun++;
            if (d !== expCnt) begin testsFailed++; $display("[TB] FAIL ovf_tcnt_edge%0d: got %02h expected %02h", e, d, expCnt); end
            readReg(6'h36, d, en);
            testsRun++;
            if (d !== ((e == 3) ? 8'h01 : 8'h00) || irq_ovf !== (e == 3)) begin
                testsFailed++; $display("[TB] FAIL ovf_flag_edge%0d: got tifr=%02h irq_ovf=%b expected tifr=%02h irq_ovf=%b",
                                        e, d, irq_ovf, (e == 3) ? 8'h01 : 8'h00, e == 3);
            end
        end
    endtask

    task automatic test_ctc_prescale();
        logic [7:0] d;
        logic       en;
        logic       prevOc;
        logic       ackNext;
        int         nEvt;
        writeReg(6'h33, 8'h00);
        writeReg(6'h32, 8'h00);
        writeReg(6'h31, 8'h04);
        writeReg(6'h36, 8'h03);
        writeReg(6'h37, 8'h00);
        prevOc  = oc0;
        ackNext = 1'b0;
        nEvt    = 0;
        writeReg(6'h33, 8'h1A);
        for (int c = 1; c <= 125; c++) begin
            irqack = ackNext; irqackad = 5'd14;
            cycle();
            irqack = 1'b0;
            readReg(6'h32, d, en);
            testsRun++;
            if (d > 8'h04) begin testsFailed++; $display("[TB] FAIL ctc_tcnt_range: got %02h expected <=04 at cycle %0d", d, c); end
            readReg(6'h36, d, en);
            ackNext = d[1];
            if (d[1]) begin
                nEvt++;
                testsRun++;
                if (c != nEvt * 40) begin testsFailed++; $display("[TB] FAIL ctc_match_cycle: got %0d expected %0d", c, nEvt * 40); end
                testsRun++;
                if (oc0 !== ~prevOc) begin testsFailed++; $display("[TB] FAIL ctc_oc0_toggle: got %b expected %b", oc0, ~prevOc); end
                prevOc = oc0;
            end
        end
        testsRun++;
        if (nEvt != 3) begin testsFailed++; $display("[TB] FAIL ctc_match_count: got %0d expected 3", nEvt); end
    endtask

    task automatic test_ack_collision();
        logic [7:0] d;
        logic       en;
        writeReg(6'h33, 8'h00);
        writeReg(6'h36, 8'h03);
        writeReg(6'h31, 8'h00);
        writeReg(6'h32, 8'hFE);
        writeReg(6'h37, 8'h03);
        writeReg(6'h33, 8'h01);
        idle(2);
        readReg(6'h36, d, en);
        testsRun++;
        if (d !== 8'h01) begin testsFailed++; $display("[TB] FAIL ack_pre_tov: got %02h expected 01", d); end
        irqack = 1'b1; irqackad = 5'd14;
        cycle();
        irqack = 1'b0;
        readReg(6'h36, d, en);
        testsRun++;
        if (d !== 8'h03 || irq_cmp !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL ack_set_wins: got tifr=%02h irq_cmp=%b expected 03 1", d, irq_cmp);
        end
        irqack = 1'b1; irqackad = 5'd14;
        cycle();
        irqack = 1'b0;
        readReg(6'h36, d, en);
        testsRun++;
        if (d !== 8'h01) begin testsFailed++; $display("[TB] FAIL ack_clears_ocf: got %02h expected 01", d); end
        irqack = 1'b1; irqackad = 5'd3;
        cycle();
        irqack = 1'b0;
        readReg(6'h36, d, en);
        testsRun++;
        if (d !== 8'h01) begin testsFailed++; $display("[TB] FAIL ack_other_ignored: got %02h expected 01", d); end
        irqack = 1'b1; irqackad = 5'd15;
        cycle();
        irqack = 1'b0;
        readReg(6'h36, d, en);
        testsRun++;
        if (d !== 8'h00 || irq_ovf !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL ack_clears_tov: got tifr=%02h irq_ovf=%b expected 00 0", d, irq_ovf);
        end
    endtask

    task automatic test_tcnt_write_collision();
        logic [7:0] d;
        logic       en;
        writeReg(6'h33, 8'h00);
        writeReg(6'h36, 8'h03);
        writeReg(6'h31, 8'h10);
        writeReg(6'h32, 8'h03);
        writeReg(6'h33, 8'h01);
        cycle();
        writeReg(6'h32, 8'h10);
        for (int k = 0; k < 3; k++) begin
            readReg(6'h32, d, en);
            testsRun++;
            if (d !== 8'(8'h10 + k)) begin testsFailed++; $display("[TB] FAIL tcntwr_value_%0d: got %02h expected %02h", k, d, 8'(8'h10 + k)); end
            readReg(6'h36, d, en);
            testsRun++;
            if (d !== 8'h00) begin testsFailed++; $display("[TB] FAIL tcntwr_no_ocf_%0d: got %02h expected 00", k, d); end
            cycle();
        end
    endtask

    task automatic test_read_path();
        logic [7:0] d;
        logic       en;
        writeReg(6'h33, 8'h00);
        writeReg(6'h31, 8'h00);
        writeReg(6'h32, 8'hFF);
        writeReg(6'h36, 8'h03);
        writeReg(6'h33, 8'h01);
        idle(2);
        writeReg(6'h33, 8'h00);
        readReg(6'h36, d, en);
        testsRun++;
        if (d !== 8'h03 || en !== 1'b1) begin testsFailed++; $display("[TB] FAIL read_tifr: got %02h en=%b expected 03 en=1", d, en); end
        readReg(6'h20, d, en);
        testsRun++;
        if (d !== 8'h00 || en !== 1'b0) begin testsFailed++; $display("[TB] FAIL read_miss: got %02h en=%b expected 00 en=0", d, en); end
        adr = 6'h36; iore = 1'b0;
        #1;
        testsRun++;
        if (dbusout !== 8'h00 || out_en !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL read_no_strobe: got %02h en=%b expected 00 en=0", dbusout, out_en);
        end
        writeReg(6'h33, 8'hF8);
        writeReg(6'h37, 8'hFF);
        readReg(6'h33, d, en);
        testsRun++;
        if (d !== 8'h38) begin testsFailed++; $display("[TB] FAIL read_tccr0_unused: got %02h expected 38", d); end
        readReg(6'h37, d, en);
        testsRun++;
        if (d !== 8'h03) begin testsFailed++; $display("[TB] FAIL read_timsk_unused: got %02h expected 03", d); end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       en;
        logic [7:0] exp;
        int         sel;
        for (int n = 0; n < 500; n++) begin
            iowe = 1'b0; irqack = 1'b0;
            if ($urandom_range(0, 99) < 25) begin
                sel    = $urandom_range(0, 5);
                adr    = (sel == 5) ? 6'h20 : regAddr(sel);
                dbusin = 8'($urandom);
                if (adr == 6'h33) dbusin[2:0] = 3'($urandom_range(0, 3));
                if (adr == 6'h32 && $urandom_range(0, 1) == 1) dbusin = 8'(8'hFA + $urandom_range(0, 5));
                if (adr == 6'h31 && $urandom_range(0, 2) == 0) dbusin = 8'hFF;
                iowe = 1'b1;
            end
            if ($urandom_range(0, 9) < 2) begin
                irqack = 1'b1;
                sel    = $urandom_range(0, 2);
                irqackad = (sel == 0) ? 5'd14 : (sel == 1) ? 5'd15 : 5'($urandom);
            end
            cycle();
            iowe = 1'b0; irqack = 1'b0;
            for (int i = 0; i < 5; i++) begin
                readReg(regAddr(i), d, en);
                exp = modelRead(regAddr(i));
                testsRun++;
                if (d !== exp || en !== 1'b1) begin
                    testsFailed++; $display("[TB] FAIL rand_reg_%02h: got %02h en=%b expected %02h en=1 (iter %0d)", regAddr(i), d, en, exp, n);
                end
            end
            testsRun++;
            if (irq_cmp !== (m_ocf != 0 && m_ocie != 0) || irq_ovf !== (m_tov != 0 && m_toie != 0) || oc0 !== (m_oc != 0)) begin
                testsFailed++; $display("[TB] FAIL rand_outputs: got irq_cmp=%b irq_ovf=%b oc0=%b expected %b %b %b (iter %0d)",
                                        irq_cmp, irq_ovf, oc0, m_ocf != 0 && m_ocie != 0, m_tov != 0 && m_toie != 0, m_oc != 0, n);
            end
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        ireset   = 1'b0;
        adr      = 6'h00;
        iore     = 1'b0;
        iowe     = 1'b0;
        dbusin   = 8'h00;
        irqack   = 1'b0;
        irqackad = 5'd0;
        modelReset();
        test_reset();
        test_overflow();
        test_ctc_prescale();
        test_ack_collision();
        test_tcnt_write_collision();
        test_read_path();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/timer0_unit.md
TIMER0_UNIT -- requirements
Module: timer0_unit

Interface
REQ-001 Parameters: IRQ_CMP_NUM, default 14, vector index acked for compare-match; IRQ_OVF_NUM, default 15, vector index acked for overflow.
REQ-002 cp2  in  1  core clock; all state updates on rising edge.
REQ-003 ireset  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 adr  in  6  I/O address from the core memory stage.
REQ-005 iore  in  1  I/O read strobe.
REQ-006 iowe  in  1  I/O write strobe.
REQ-007 dbusin  in  8  write data (the core's dbusout).
REQ-008 dbusout  out  8  read data toward the core's dbusin mux.
REQ-009 out_en  out  1  high when dbusout carries a valid read of this block.
REQ-010 irqack  in  1  core interrupt-acknowledge pulse.
REQ-011 irqackad  in  5  acknowledged vector index (core arqackar).
REQ-012 irq_cmp  out  1  compare-match request, to one core irqlines bit.
REQ-013 irq_ovf  out  1  overflow request, to one core irqlines bit.
REQ-014 oc0  out  1  output-compare pin.

Function
REQ-015 Registers: OCR0 0x31, TCNT0 0x32, TCCR0 0x33, TIFR 0x36 (bit0 TOV0, bit1 OCF0), TIMSK 0x37 (bit0 TOIE0, bit1 OCIE0); unused bits read 0.
REQ-016 TCCR0: [2:0] CS0, [3] CTC0, [5:4] COM0; [7:6] read 0.
REQ-017 Reads combinational: out_en = iore & address hit; dbusout = selected register, 0x00 when out_en low.
REQ-018 Writes take effect at the edge where iowe is high; TIFR write clears each flag whose data bit is 1 (write-1-to-clear).
REQ-019 Prescaler: 10-bit free-running counter, held at 0 while CS0=0; tick every cycle for CS0=1, else once per 8/32/64/128/256/1024 cycles for CS0=2..7 (tick when counter low bits all ones).
REQ-020 On tick: TCNT0==OCR0 sets OCF0; if also CTC0, TCNT0 <- 0, else TCNT0 <- TCNT0+1 mod 256.
REQ-021 Any transition 0xFF -> 0x00 on tick sets TOV0, including the CTC clear with OCR0=0xFF.
REQ-022 CPU write to TCNT0 on a tick edge: write wins, no increment; compare match suppressed on the first tick after the write.
REQ-023 Flag-set vs. clear (TIFR write or matching ack) on the same edge: set wins.
REQ-024 irqack with irqackad==IRQ_CMP_NUM clears OCF0; with IRQ_OVF_NUM clears TOV0; other indices ignored.
REQ-025 irq_cmp = OCF0 & OCIE0; irq_ovf = TOV0 & TOIE0; combinational from registered state.
REQ-026 oc0 on compare match: COM0=00 unchanged, 01 toggle, 10 clear, 11 set; registered, same edge as OCF0.
REQ-027 Changing CS0 does not reset prescaler or TCNT0; CS0 -> 0 freezes TCNT0 immediately.

Reset
REQ-028 ireset low asynchronously forces all registers, prescaler, flags and oc0 to 0; irq_cmp, irq_ovf, out_en, dbusout read 0.
REQ-029 Reset mid-count discards the count; after release, no tick until TCCR0 written with CS0!=0.

Structure
REQ-030 Shared package holds I/O address constants, TIFR/TIMSK bit positions, CS0 encodings and COM0 encodings.
REQ-031 One sub-module, timer0_prescaler (CS0 in, tick out); register file, counter and flags in the top.

Verification
REQ-032 Reset: ireset low mid-count with CS0=1 -> all registers read 0x00, irq_cmp=irq_ovf=0, oc0=0 in the same cycle.
REQ-033 Overflow: TCNT0=0xFD, TIMSK=0x01, TCCR0=0x01 -> TOV0 and irq_ovf rise on the 3rd edge; TCNT0 reads 0x00.
REQ-034 CTC/prescale: OCR0=0x04, TCCR0=0x1A (CTC, toggle, /8) -> OCF0 set and oc0 toggles every 40 cycles; TCNT0 never exceeds 4.
REQ-035 Ack vs. set collision: irqack with irqackad=IRQ_CMP_NUM on the match edge -> OCF0 stays 1; ack one cycle later -> OCF0=0, TOV0 untouched.
REQ-036 TCNT0 write collision: write 0x10 on a tick edge with OCR0=0x10 -> TCNT0=0x10, no OCF0; next tick -> 0x11, no match.
REQ-037 Read path: iore with adr=0x36 and TIFR=0x03 -> out_en=1, dbusout=0x03; adr=0x20 -> out_en=0, dbusout=0x00.
